pulse_source_gen: RTL and testbench
===================================

Name: pulse_source_gen

Overview:
- Programmable square-wave/PWM source: the transmit end of the measurement path.
- Produces the test signal that the frequency, period and duty meters consume. Period and high time are set in clock cycles from switches or registers.
- New settings are taken only at period boundaries, so the meters never see a torn period.
- Sits beside the meters under the top level; SigOut feeds the meter input directly.

Parameters:
- CNT_W, 24, width of the period and high-time counters (2^24 cycles covers below 6 Hz at 100 MHz).
- CNT_OUT_W, 16, width of the completed-period counter.

Ports:
- Clk  in  1  system clock (100 MHz on board).
- Rst  in  1  synchronous reset, active-high.
- Start  in  1  single-cycle pulse: begin generating.
- Stop  in  1  single-cycle pulse: finish the current period, then idle.
- PeriodCyc  in  CNT_W  requested period in Clk cycles.
- HighCyc  in  CNT_W  requested high time in Clk cycles.
- Load  in  1  single-cycle pulse: capture PeriodCyc/HighCyc into the pending register.
- LoadAck  out  1  one-cycle pulse when pending settings become active.
- Busy  out  1  high while not IDLE.
- SigOut  out  1  generated waveform.
- PeriodDone  out  1  one-cycle pulse on the last cycle of each period.
- CfgErr  out  1  sticky: the last captured configuration had PeriodCyc<2.
- PeriodCount  out  CNT_OUT_W  completed periods since Start; wraps modulo 2^CNT_OUT_W.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - Active and pending registers get PeriodCyc=2, HighCyc=1; pending-valid flag cleared.
- Configuration capture:
  - Load registers the inputs into pending and sets the pending-valid flag (PV).
  - A second Load before application overwrites pending; only one LoadAck is issued.
- Configuration application:
  - In IDLE with PV set: applied on the next cycle.
  - While running: applied on the cycle the phase counter wraps to a new period.
  - Application copies pending to active, clears PV and pulses LoadAck.
  - A Load on the same cycle as application: the new value stays pending with PV set, and is applied at the next boundary.
- Configuration validation:
  - CfgErr is set when PeriodCyc<2 is applied; that config is discarded and the previous active config kept.
  - CfgErr is cleared by the next valid application or by Rst.
- FSM states: IDLE, HIGH, LOW, DRAIN.
  - IDLE: SigOut=0. On Start go to HIGH if active HighCyc>0, else LOW. Load the phase counter with 1 and clear PeriodCount.
  - HIGH: SigOut=1. Counter increments each cycle. When counter==HighCyc go to LOW, unless HighCyc>=PeriodCyc (constant-high, period ends at counter==PeriodCyc).
  - LOW: SigOut=0. When counter==PeriodCyc the period ends.
    - PeriodDone=1 and PeriodCount+1 on that cycle; counter reloads 1.
    - Next state is HIGH (or LOW if HighCyc==0).
    - Pending config is applied at this point.
  - DRAIN: entered from HIGH/LOW when Stop is seen. Waveform continues unchanged until period end, then IDLE with SigOut=0 and PeriodDone pulsed.
- Timing and priority:
  - Start latency: SigOut rises on the cycle after Start is sampled.
  - Exact high time is HighCyc cycles; exact period is PeriodCyc cycles.
  - Start while Busy is ignored. Stop in IDLE is ignored. Start and Stop in the same cycle from IDLE: Start wins, Stop is ignored.
- Reset mid-operation returns to IDLE next cycle, SigOut=0, pending discarded.
- Outputs are registered; SigOut is glitch-free.

Test Plan:
1. Rst, Load Period=10/High=3, Start → LoadAck 1 cycle later. SigOut is 3 high then 7 low, repeating. PeriodDone every 10 cycles; PeriodCount=5 after 50 cycles.
2. While running 10/3, Load 8/4 mid-HIGH → first period remains 3/7. LoadAck and the switch occur at the boundary; next period is 4 high/4 low.
3. Load Period=1 → CfgErr=1 and the previous 10/3 is retained. Load 6/0 → CfgErr clears and SigOut stays constant 0, with PeriodDone every 6 cycles.
4. High=12, Period=12 → SigOut constant 1; PeriodDone every 12 cycles.
5. Stop asserted 2 cycles into a 10/3 period → remaining 8 cycles complete (Busy=1), then Busy=0 and SigOut=0. Assert Rst mid-HIGH → SigOut=0 and Busy=0 the next cycle.
6. CNT_OUT_W=4, run 17 periods of 2/1 → PeriodCount wraps to 1.

Source files
------------

// File: rtl/pulse_source_gen.sv
// pulse_source_gen
// Programmable square-wave / PWM source driving the frequency, period and duty
// meters. Period and high time are given in Clk cycles. New settings are only
// switched in at period boundaries, so a consumer never sees a torn period.
//
// Ports
//   Clk          system clock
//   Rst          synchronous reset, active high
//   Start        pulse: begin generating (ignored while Busy)
//   Stop         pulse: finish the current period, then go idle
//   PeriodCyc    requested period in Clk cycles (must be >= 2)
//   HighCyc      requested high time in Clk cycles
//   Load         pulse: capture PeriodCyc/HighCyc into the pending register
//   LoadAck      pulse: pending settings have just become active
//   Busy         high while the generator is not idle
//   SigOut       generated waveform (registered, glitch-free)
//   PeriodDone   pulse during the last cycle of every period
//   CfgErr       sticky: last applied configuration had PeriodCyc < 2
//   PeriodCount  periods completed since Start, wraps modulo 2^CNT_OUT_W

module pulse_source_gen #(
  parameter int CNT_W     = 24,
  parameter int CNT_OUT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Stop,
  input  logic [CNT_W-1:0]     PeriodCyc,
  input  logic [CNT_W-1:0]     HighCyc,
  input  logic                 Load,
  output logic                 LoadAck,
  output logic                 Busy,
  output logic                 SigOut,
  output logic                 PeriodDone,
  output logic                 CfgErr,
  output logic [CNT_OUT_W-1:0] PeriodCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  state_t           state;
  logic [CNT_W-1:0] cnt;          // phase within the period, 1..act_period
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_high;
  logic             pend_valid;

  logic             running;
  logic             period_end;
  logic             apply_cfg;
  logic             pend_ok;
  logic [CNT_W-1:0] new_high;
  logic [CNT_W-1:0] cnt_inc;
  logic             next_high;
  logic             next_last;

  assign running    = (state != IDLE);
  // The current cycle is the last one of the running period.
  assign period_end = running && (cnt == act_period);
  // Pending settings are taken while idle or exactly at a period boundary.
  assign apply_cfg  = pend_valid && (!running || period_end);
  assign pend_ok    = (pend_period >= MIN_PERIOD);
  // High time that governs the cycle after a boundary: the pending value if
  // it is being accepted right now, otherwise the active one.
  assign new_high   = (apply_cfg && pend_ok) ? pend_high : act_high;
  assign cnt_inc    = cnt + ONE;
  // The waveform level is derived from the phase counter, which covers the
  // constant-low (HighCyc==0) and constant-high (HighCyc>=PeriodCyc) cases
  // without special states, and keeps DRAIN identical to HIGH/LOW.
  assign next_high  = (cnt_inc <= act_high);
  // All outputs are registered, so PeriodDone is raised one cycle early to
  // land on the last cycle of the period itself.
  assign next_last  = (cnt_inc == act_period);

  always_ff @(posedge Clk) begin
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; a blocking = would let later lines see
    // half-updated state and the simulation would no longer match the netlist.
    if (Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      act_period  <= MIN_PERIOD;
      act_high    <= ONE;
      pend_period <= MIN_PERIOD;
      pend_high   <= ONE;
      pend_valid  <= 1'b0;
      LoadAck     <= 1'b0;
      Busy        <= 1'b0;
      SigOut      <= 1'b0;
      PeriodDone  <= 1'b0;
      CfgErr      <= 1'b0;
      PeriodCount <= '0;
    end else begin
      LoadAck    <= 1'b0;
      PeriodDone <= 1'b0;

      // A Load coinciding with an application wins the pending register, so
      // the newer value waits for the following boundary.
      if (Load) begin
        pend_period <= PeriodCyc;
        pend_high   <= HighCyc;
        pend_valid  <= 1'b1;
      end else if (apply_cfg) begin
        pend_valid <= 1'b0;
      end

      // An unusable period is dropped and the previous settings stay active.
      if (apply_cfg) begin
        if (pend_ok) begin
          act_period <= pend_period;
          act_high   <= pend_high;
          CfgErr     <= 1'b0;
          LoadAck    <= 1'b1;
        end else begin
          CfgErr <= 1'b1;
        end
      end

      if (!running) begin
        // Stop is ignored here, so Start wins when both arrive together.
        if (Start) begin
          state       <= (new_high != '0) ? HIGH : LOW;
          cnt         <= ONE;
          SigOut      <= (new_high != '0);
          Busy        <= 1'b1;
          PeriodCount <= '0;
        end
      end else if (period_end) begin
        if (state == DRAIN || Stop) begin
          state  <= IDLE;
          cnt    <= '0;
          SigOut <= 1'b0;
          Busy   <= 1'b0;
        end else begin
          state  <= (new_high != '0) ? HIGH : LOW;
          cnt    <= ONE;
          SigOut <= (new_high != '0);
        end
      end else begin
        cnt        <= cnt_inc;
        SigOut     <= next_high;
        PeriodDone <= next_last;
        if (next_last) begin
          PeriodCount <= PeriodCount + 1'b1;
        end
        // DRAIN keeps the waveform running until the boundary; only the
        // state label stops tracking the phase.
        if (state != DRAIN) begin
          state <= Stop ? DRAIN : (next_high ? HIGH : LOW);
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_source_gen.sv
// Self-checking bench for pulse_source_gen: a vector table for reset, load
// and the first period, then hand-written multi-period sequences for
// boundary application, config errors, constant levels, stop, reset and wrap.

module tb_pulse_source_gen;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic [23:0] PeriodCyc = '0;
  logic [23:0] HighCyc = '0;
  logic        Load = 1'b0;
  logic        LoadAck;
  logic        Busy;
  logic        SigOut;
  logic        PeriodDone;
  logic        CfgErr;
  logic [3:0]  PeriodCount;

  int n_vec = 0;
  int n_err = 0;

  pulse_source_gen #(
    .CNT_W     (24),
    .CNT_OUT_W (4)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .Stop        (Stop),
    .PeriodCyc   (PeriodCyc),
    .HighCyc     (HighCyc),
    .Load        (Load),
    .LoadAck     (LoadAck),
    .Busy        (Busy),
    .SigOut      (SigOut),
    .PeriodDone  (PeriodDone),
    .CfgErr      (CfgErr),
    .PeriodCount (PeriodCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, start, stop, load;
    logic [23:0] period, high;
    logic        sig, busy, done, ack, err;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic rst, start, stop, load,
                              input logic [23:0] period, high,
                              input logic sig, busy, done, ack, err,
                              input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.stop = stop; v.load = load;
    v.period = period; v.high = high;
    v.sig = sig; v.busy = busy; v.done = done; v.ack = ack; v.err = err;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are changed at the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Runs from the last cycle of one period through the last cycle of the
  // next one. Load is raised before tick index la1 / la2 (index 0 is sampled
  // on the boundary edge itself).
  task automatic period(input string name,
                        input int la1, input logic [23:0] p1, h1,
                        input int la2, input logic [23:0] p2, h2,
                        input int exp_hi, exp_len, exp_acks, input logic exp_err);
    int   hi = 0;
    int   len = 0;
    int   acks = 0;
    logic got = 1'b0;
    logic err_last = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (i == la1) begin
        Load = 1'b1; PeriodCyc = p1; HighCyc = h1;
      end else if (i == la2) begin
        Load = 1'b1; PeriodCyc = p2; HighCyc = h2;
      end
      tick();
      Load = 1'b0;
      len++;
      if (SigOut) hi++;
      if (LoadAck) acks++;
      if (PeriodDone) begin
        got = 1'b1;
        err_last = CfgErr;
      end
    end
    check({name, ".done_seen"}, got, 1);
    check({name, ".high"}, hi, exp_hi);
    check({name, ".len"}, len, exp_len);
    check({name, ".acks"}, acks, exp_acks);
    check({name, ".err"}, err_last, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dones;
    int acks;
    int cyc;

    //           rst st sp ld per hi   sig busy done ack err cnt
    vecs[0]  = mk(1, 0, 0, 0,  0, 0,   0,  0,   0,   0,  0,  0);
    vecs[1]  = mk(0, 0, 0, 1, 10, 3,   0,  0,   0,   0,  0,  0);
    vecs[2]  = mk(0, 0, 0, 0,  0, 0,   0,  0,   0,   1,  0,  0);
    vecs[3]  = mk(0, 0, 0, 0,  0, 0,   0,  0,   0,   0,  0,  0);
    vecs[4]  = mk(0, 1, 0, 0,  0, 0,   1,  1,   0,   0,  0,  0);
    vecs[5]  = mk(0, 0, 0, 0,  0, 0,   1,  1,   0,   0,  0,  0);
    vecs[6]  = mk(0, 0, 0, 0,  0, 0,   1,  1,   0,   0,  0,  0);
    vecs[7]  = mk(0, 0, 0, 0,  0, 0,   0,  1,   0,   0,  0,  0);
    vecs[8]  = mk(0, 0, 0, 0,  0, 0,   0,  1,   0,   0,  0,  0);
    vecs[9]  = mk(0, 0, 0, 0,  0, 0,   0,  1,   0,   0,  0,  0);
    vecs[10] = mk(0, 0, 0, 0,  0, 0,   0,  1,   0,   0,  0,  0);
    vecs[11] = mk(0, 0, 0, 0,  0, 0,   0,  1,   0,   0,  0,  0);
    vecs[12] = mk(0, 0, 0, 0,  0, 0,   0,  1,   0,   0,  0,  0);
    vecs[13] = mk(0, 0, 0, 0,  0, 0,   0,  1,   1,   0,  0,  1);
    vecs[14] = mk(0, 0, 0, 0,  0, 0,   1,  1,   0,   0,  0,  1);

    // Reset, load 10/3 while idle, start, first period and wrap.
    for (int i = 0; i < 15; i++) begin
      Rst = vecs[i].rst; Start = vecs[i].start; Stop = vecs[i].stop;
      Load = vecs[i].load; PeriodCyc = vecs[i].period; HighCyc = vecs[i].high;
      tick();
      check($sformatf("v%0d.sig", i),  SigOut,      vecs[i].sig);
      check($sformatf("v%0d.busy", i), Busy,        vecs[i].busy);
      check($sformatf("v%0d.done", i), PeriodDone,  vecs[i].done);
      check($sformatf("v%0d.ack", i),  LoadAck,     vecs[i].ack);
      check($sformatf("v%0d.err", i),  CfgErr,      vecs[i].err);
      check($sformatf("v%0d.cnt", i),  PeriodCount, vecs[i].cnt);
    end
    Rst = 1'b0; Start = 1'b0; Stop = 1'b0; Load = 1'b0;

    // Cycles 12..50: four more boundaries, five periods in total.
    dones = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (PeriodDone) dones++;
    end
    check("run50.dones", dones, 4);
    check("run50.done_now", PeriodDone, 1);
    check("run50.count", PeriodCount, 5);

    // Bad period while running: discarded, 10/3 kept, CfgErr raised.
    period("p6",  1, 24'd1,  24'd5, -1, 24'd0, 24'd0,  3, 10, 0, 1'b0);
    // Two Loads mid-HIGH: the second overwrites, one LoadAck at the boundary.
    period("p7",  1, 24'd9,  24'd2,  3, 24'd8, 24'd4,  3, 10, 0, 1'b1);
    period("p8", -1, 24'd0,  24'd0, -1, 24'd0, 24'd0,  4,  8, 1, 1'b0);
    // 6/0 pending; 12/12 loaded on the very edge 6/0 is applied.
    period("p9",  1, 24'd6,  24'd0, -1, 24'd0, 24'd0,  4,  8, 0, 1'b0);
    period("p10", 0, 24'd12, 24'd12, -1, 24'd0, 24'd0, 0,  6, 1, 1'b0);
    period("p11", -1, 24'd0, 24'd0, -1, 24'd0, 24'd0, 12, 12, 1, 1'b0);
    period("p12", 1, 24'd10, 24'd3, -1, 24'd0, 24'd0, 12, 12, 0, 1'b0);
    period("p13", -1, 24'd0, 24'd0, -1, 24'd0, 24'd0,  3, 10, 1, 1'b0);

    // Stop sampled at the end of cycle 2 of a 10/3 period: 8 cycles drain.
    tick();
    tick();
    Stop = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      tick();
      Stop = 1'b0;
      check($sformatf("drain%0d.busy", c), Busy, 1);
      check($sformatf("drain%0d.sig", c), SigOut, (c == 3) ? 1 : 0);
      check($sformatf("drain%0d.done", c), PeriodDone, (c == 10) ? 1 : 0);
    end
    check("drain.count", PeriodCount, 14);
    tick();
    check("stopped.busy", Busy, 0);
    check("stopped.sig", SigOut, 0);
    check("stopped.done", PeriodDone, 0);

    // Reset mid-HIGH with a Load pending: back to idle and defaults.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("restart.sig", SigOut, 1);
    Load = 1'b1; PeriodCyc = 24'd4; HighCyc = 24'd2;
    tick();
    Load = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("rst.sig", SigOut, 0);
    check("rst.busy", Busy, 0);
    check("rst.count", PeriodCount, 0);

    // Start+Stop together from idle: Start wins, default 2/1 runs.
    // A Start while busy is ignored; 17 periods wrap the 4-bit count to 1.
    Start = 1'b1; Stop = 1'b1;
    tick();
    Start = 1'b0; Stop = 1'b0;
    cyc = 1; dones = 0; acks = 0;
    check("wrap.busy", Busy, 1);
    check("wrap.sig1", SigOut, 1);
    for (int i = 0; i < 100 && dones < 17; i++) begin
      if (i == 4) Start = 1'b1;
      tick();
      Start = 1'b0;
      cyc++;
      check($sformatf("wrap.sig%0d", cyc), SigOut, cyc % 2);
      if (PeriodDone) dones++;
      if (LoadAck) acks++;
    end
    check("wrap.dones", dones, 17);
    check("wrap.cycles", cyc, 34);
    check("wrap.count", PeriodCount, 1);
    check("wrap.acks", acks, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
